rom_port_arb: RTL and testbench
===============================

Name: rom_port_arb

Overview:
- Shares one single-port cartridge ROM RAM (32 KB, byte-wide) between the HPS download writer (ioctl_*) and the console core's cartridge fetch port.
- Buffers one download byte and back-pressures HPS via ioctl_wait. Gives CPU fetches priority, with an anti-starvation guard for the writer.
- At download end it reports the loaded ROM size for bank-switch auto-detection.
- Sits in emu between hps_io, the ROM RAM and A2601top.

Parameters:
- RD_LAT, 1, memory read latency in cycles from mem_addr valid to mem_dout valid (1..3).
- MAX_WAIT, 4, cycles a buffered write may be held off by CPU reads before it is forced (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  download active
- ioctl_wr  in  1  download byte strobe (one-cycle pulse)
- ioctl_addr  in  25  download byte address
- ioctl_dout  in  8  download byte
- ioctl_wait  out  1  write buffer full; HPS must hold the next ioctl_wr
- cpu_req  in  1  fetch request pulse
- cpu_addr  in  15  fetch address
- cpu_data  out  8  fetched byte, registered
- cpu_ack  out  1  one-cycle pulse, cpu_data valid
- mem_addr  out  15  RAM address, registered
- mem_din  out  8  RAM write data, registered
- mem_we  out  1  RAM write enable, registered
- mem_dout  in  8  RAM read data
- rom_size  out  17  highest accepted address+1, latched at download end
- load_done  out  1  one-cycle pulse on falling edge of ioctl_download
- addr_ovf  out  1  sticky: a byte with ioctl_addr[24:15]!=0 was dropped in this download

Behaviour:
- Reset values: ioctl_wait=0, cpu_data=0, cpu_ack=0, mem_addr=0, mem_din=0, mem_we=0, rom_size=0, load_done=0, addr_ovf=0. Reset also clears the write buffer, CPU pending, the wait counter and the FSM (to IDLE). Reset during RD or WR aborts the access with no ack; the buffered byte is lost.
- Write buffer (1 entry):
  - ioctl_wr with ioctl_addr[24:15]==0 loads the buffer and sets wbuf_v.
  - A byte with a nonzero upper address is dropped and sets addr_ovf; it never occupies the buffer.
  - ioctl_wait = wbuf_v, registered: it is high the cycle after the load and drops the cycle after the write issues.
  - ioctl_wr while wbuf_v=1 is a protocol violation; the byte is dropped and the buffer is unchanged.
- CPU pending (1 entry): cpu_req latches cpu_addr and sets cpu_p. A cpu_req while cpu_p is set overwrites the address (latest wins, one ack total).
- FSM:
  - IDLE, nothing pending: stay in IDLE.
  - IDLE, both pending, wait_cnt==MAX_WAIT: go to WR.
  - IDLE, cpu_p (including a request arriving this cycle): go to RD. Drive mem_addr=cpu address, mem_we=0, clear cpu_p.
  - IDLE, wbuf_v only: go to WR.
  - RD: wait RD_LAT cycles. On the cycle mem_dout is valid, register it into cpu_data and pulse cpu_ack next cycle. Return to IDLE.
  - WR: mem_addr=buf addr, mem_din=buf data, mem_we=1 for exactly one cycle. Clear wbuf_v, reset wait_cnt, return to IDLE.
  - mem_we is 0 in every state except WR.
- Read latency: cpu_req at cycle N with the arbiter idle gives mem_addr valid at N+1 and cpu_ack at N+1+RD_LAT+1. With RD_LAT=1, the ack arrives at N+3.
- wait_cnt (4 bit, saturating): increments each cycle wbuf_v=1 and an RD is granted or in progress; cleared on WR.
- Size tracking:
  - On the ioctl_download rising edge, clear max_addr and addr_ovf.
  - Each accepted byte updates max_addr = max(max_addr, addr+1), 17-bit arithmetic (max 32768).
  - On the falling edge, rom_size<=max_addr and load_done pulses one cycle. This happens after the buffered write completes: if wbuf_v=1 at the falling edge, both are delayed until the WR finishes.
- Simultaneous events:
  - cpu_req and ioctl_wr in the same cycle: both are latched; the CPU is served first unless wait_cnt==MAX_WAIT.
  - A CPU fetch during a download is legal; the data returned is the RAM's current content.

Test Plan:
- Idle fetch, RD_LAT=1: RAM[0x0123]=0x5A; cpu_req at cycle 10 addr 0x0123 -> mem_addr=0x0123 at 11, cpu_ack pulse at 13 with cpu_data=0x5A, mem_we never high.
- Download: bytes 0xA0,0xA1,0xA2 to addr 0..2 with HPS honouring ioctl_wait -> three mem_we pulses at addr 0,1,2 with the matching data. ioctl_wait high exactly one cycle per byte. Download end -> load_done pulse, rom_size=3, addr_ovf=0.
- Contention, MAX_WAIT=4: buffered write plus cpu_req every 3 cycles back-to-back -> the write issues after at most 4 granted-read cycles. Every CPU request is acked, none lost.
- Overflow: ioctl_wr to addr 0x8000 then 0x7FFF -> the first byte is not written and addr_ovf=1. The second byte is written, and rom_size=32768 (0x8000) at end.
- Simultaneous: cpu_req (0x0010) and ioctl_wr (0x0020,0x77) in the same cycle -> RD issues first and is acked, then WR to 0x0020; a read of 0x0020 afterwards returns 0x77.
- Reset mid-RD: assert reset the cycle after mem_addr issues -> no cpu_ack, all outputs at reset values next cycle. A new cpu_req after reset is served normally.

Source files
------------

// File: rtl/rom_port_arb.sv
// Cartridge ROM port arbiter: shares one byte-wide single-port RAM between
// the HPS download writer and the console cartridge fetch port. CPU fetches
// win arbitration unless a buffered write has waited MAX_WAIT read cycles.
module rom_port_arb #(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        cpu_req,
  input  logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data,
  output logic        cpu_ack,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout,
  output logic [16:0] rom_size,
  output logic        load_done,
  output logic        addr_ovf
);

  localparam logic [1:0] RD_L  = 2'(RD_LAT);
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t      state;
  logic [1:0]  rd_cnt;
  logic        wbuf_v;
  logic [14:0] wbuf_a;
  logic [7:0]  wbuf_d;
  logic        cpu_p;
  logic [14:0] cpu_a;
  logic [3:0]  wait_cnt;
  logic        dl_p1;
  logic        end_pend;
  logic [16:0] max_addr;

  logic        cpu_any;
  logic [14:0] cpu_sel;
  logic        force_wr;
  logic        wr_grant;
  logic        rd_grant;
  logic        wr_ok;
  logic        wr_ovf;
  logic        dl_rise;
  logic        dl_fall;
  logic [16:0] addr_inc;
  logic [16:0] max_base;
  logic [16:0] max_next;
  logic        end_fire;

  // The buffer-full flag is itself a register, so the HPS sees it one cycle after a load.
  assign ioctl_wait = wbuf_v;

  // Arbitration and bookkeeping decisions for the current cycle.
  always_comb begin
    cpu_any  = cpu_p | cpu_req;
    // A request arriving this cycle carries the newest address.
    cpu_sel  = cpu_req ? cpu_addr : cpu_a;
    force_wr = (wait_cnt >= MAX_W);
    wr_grant = (state == S_IDLE) && wbuf_v && (!cpu_any || force_wr);
    rd_grant = (state == S_IDLE) && cpu_any && !wr_grant;
    wr_ok    = ioctl_wr && (ioctl_addr[24:15] == 10'd0) && !wbuf_v;
    wr_ovf   = ioctl_wr && (ioctl_addr[24:15] != 10'd0);
    dl_rise  = ioctl_download & ~dl_p1;
    dl_fall  = ~ioctl_download & dl_p1;
    addr_inc = {2'b00, ioctl_addr[14:0]} + 17'd1;
    max_base = dl_rise ? 17'd0 : max_addr;
    max_next = (wr_ok && (addr_inc > max_base)) ? addr_inc : max_base;
    // Download end is reported only once no write is buffered or in flight.
    end_fire = (dl_fall | end_pend) && !wbuf_v && (state != S_WR) && !wr_ok;
  end

  // Memory port FSM: issues reads and writes and returns fetched bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rd_cnt   <= 2'd0;
      mem_addr <= 15'd0;
      mem_din  <= 8'd0;
      mem_we   <= 1'b0;
      cpu_data <= 8'd0;
      cpu_ack  <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_grant) begin
            mem_addr <= wbuf_a;
            mem_din  <= wbuf_d;
            mem_we   <= 1'b1;
            state    <= S_WR;
          end else if (rd_grant) begin
            mem_addr <= cpu_sel;
            rd_cnt   <= 2'd0;
            state    <= S_RD;
          end
        end
        S_RD: begin
          if (rd_cnt == RD_L) begin
            cpu_data <= mem_dout;
            cpu_ack  <= 1'b1;
            state    <= S_IDLE;
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end
        S_WR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Write-buffer / CPU-pending valid flags and the writer starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbuf_v   <= 1'b0;
      cpu_p    <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      if (wr_grant)
        wbuf_v <= 1'b0;
      else if (wr_ok)
        wbuf_v <= 1'b1;

      if (rd_grant)
        cpu_p <= 1'b0;
      else if (cpu_req)
        cpu_p <= 1'b1;

      // Saturates at the force threshold so the forced grant cannot be skipped.
      if (wr_grant)
        wait_cnt <= 4'd0;
      else if (wbuf_v && (rd_grant || state == S_RD) && (wait_cnt < MAX_W))
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Buffered write data and latched fetch address (no reset needed).
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      wbuf_a <= ioctl_addr[14:0];
      wbuf_d <= ioctl_dout;
    end
    if (cpu_req)
      cpu_a <= cpu_addr;
  end

  // Download size tracking, overflow flag and end-of-load reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_p1     <= 1'b0;
      end_pend  <= 1'b0;
      max_addr  <= 17'd0;
      rom_size  <= 17'd0;
      load_done <= 1'b0;
      addr_ovf  <= 1'b0;
    end else begin
      dl_p1     <= ioctl_download;
      load_done <= 1'b0;
      max_addr  <= max_next;

      if (dl_rise)
        addr_ovf <= wr_ovf;
      else if (wr_ovf)
        addr_ovf <= 1'b1;

      if (end_fire) begin
        rom_size  <= max_next;
        load_done <= 1'b1;
        end_pend  <= 1'b0;
      end else if (dl_fall) begin
        end_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arb.sv
// Directed bench for rom_port_arb with a behavioural 1-cycle-latency ROM RAM.
module tb_rom_port_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        cpu_req;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_ack;
  logic [14:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic [16:0] rom_size;
  logic        load_done;
  logic        addr_ovf;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  rom_port_arb #(.RD_LAT(1), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .rom_size(rom_size), .load_done(load_done), .addr_ovf(addr_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Untouched locations hold a fixed pattern; 0x0123 holds 0x5A.
  function automatic logic [7:0] init_val(input logic [14:0] a);
    return (a == 15'h0123) ? 8'h5A : (a[7:0] ^ 8'hC3);
  endfunction

  logic [7:0] ram [0:32767];
  bit         written [0:32767];

  // Single-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]     <= mem_din;
      written[mem_addr] <= 1'b1;
    end
    mem_dout <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  logic [22:0] we_q[$];
  logic [7:0]  ack_q[$];
  int          we_cyc, ack_cyc, wait_hi, ld_cnt;

  // Observe DUT outputs mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      we_q.push_back({mem_addr, mem_din});
      we_cyc = cyc;
    end
    if (cpu_ack) begin
      ack_q.push_back(cpu_data);
      ack_cyc = cyc;
    end
    if (ioctl_wait) wait_hi++;
    if (load_done) ld_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    we_q.delete();
    ack_q.delete();
    we_cyc  = 0;
    ack_cyc = 0;
    wait_hi = 0;
    ld_cnt  = 0;
  endtask

  task automatic hps_write(input logic [24:0] a, input logic [7:0] d);
    int b = 0;
    while (ioctl_wait && b < 50) begin
      tick();
      b++;
    end
    if (b >= 50) chk("hps_wait_timeout", 32'(ioctl_wait), 32'd0);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_ioctl_wait"}, 32'(ioctl_wait), 32'd0);
    chk({pfx, "_cpu_data"},   32'(cpu_data),   32'd0);
    chk({pfx, "_cpu_ack"},    32'(cpu_ack),    32'd0);
    chk({pfx, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({pfx, "_mem_din"},    32'(mem_din),    32'd0);
    chk({pfx, "_mem_we"},     32'(mem_we),     32'd0);
    chk({pfx, "_rom_size"},   32'(rom_size),   32'd0);
    chk({pfx, "_load_done"},  32'(load_done),  32'd0);
    chk({pfx, "_addr_ovf"},   32'(addr_ovf),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; cpu_req = 1'b0; cpu_addr = '0;
    repeat (3) tick();
    chk_reset_outs("rst");
    reset = 1'b0;
    repeat (2) tick();

    // Idle fetch of 0x0123
    clr_mon();
    cpu_req = 1'b1; cpu_addr = 15'h0123; n0 = cyc;
    tick();
    cpu_req = 1'b0;
    chk("fetch_mem_addr", 32'(mem_addr), 32'h0123);
    tick();
    chk("fetch_ack_early", 32'(cpu_ack), 32'd0);
    tick();
    chk("fetch_ack", 32'(cpu_ack), 32'd1);
    chk("fetch_data", 32'(cpu_data), 32'h5A);
    chk("fetch_lat", 32'(cyc - n0), 32'd3);
    tick();
    chk("fetch_ack_pulse", 32'(cpu_ack), 32'd0);
    chk("fetch_no_we", 32'(we_q.size()), 32'd0);

    // Download three bytes
    clr_mon();
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) hps_write(25'(i), 8'hA0 + 8'(i));
    ioctl_download = 1'b0;
    repeat (8) tick();
    chk("dl_we_count", 32'(we_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < we_q.size(); i++)
      chk("dl_we_entry", 32'(we_q[i]), 32'({15'(i), 8'hA0 + 8'(i)}));
    chk("dl_wait_cycles", 32'(wait_hi), 32'd3);
    chk("dl_load_done", 32'(ld_cnt), 32'd1);
    chk("dl_rom_size", 32'(rom_size), 32'd3);
    chk("dl_addr_ovf", 32'(addr_ovf), 32'd0);

    // Overflow address then top-of-ROM byte
    clr_mon();
    ioctl_download = 1'b1;
    tick();
    hps_write(25'h0008000, 8'h11);
    tick();
    chk("ovf_flag", 32'(addr_ovf), 32'd1);
    chk("ovf_no_we", 32'(we_q.size()), 32'd0);
    chk("ovf_no_wait", 32'(ioctl_wait), 32'd0);
    hps_write(25'h0007FFF, 8'h22);
    ioctl_download = 1'b0;
    repeat (8) tick();
    chk("ovf_we_count", 32'(we_q.size()), 32'd1);
    if (we_q.size() > 0) chk("ovf_we_entry", 32'(we_q[0]), 32'({15'h7FFF, 8'h22}));
    chk("ovf_rom_size", 32'(rom_size), 32'h8000);
    chk("ovf_sticky", 32'(addr_ovf), 32'd1);
    chk("ovf_load_done", 32'(ld_cnt), 32'd1);

    // Simultaneous fetch and download byte
    clr_mon();
    ioctl_download = 1'b1;
    tick();
    chk("sim_ovf_cleared", 32'(addr_ovf), 32'd0);
    cpu_req = 1'b1; cpu_addr = 15'h0010;
    ioctl_wr = 1'b1; ioctl_addr = 25'h20; ioctl_dout = 8'h77; n0 = cyc;
    tick();
    cpu_req = 1'b0; ioctl_wr = 1'b0;
    repeat (6) tick();
    chk("sim_ack_count", 32'(ack_q.size()), 32'd1);
    if (ack_q.size() > 0) chk("sim_ack_data", 32'(ack_q[0]), 32'hD3);
    chk("sim_ack_cyc", 32'(ack_cyc - n0), 32'd3);
    chk("sim_we_cyc", 32'(we_cyc - n0), 32'd4);
    if (we_q.size() > 0) chk("sim_we_entry", 32'(we_q[0]), 32'({15'h0020, 8'h77}));
    cpu_req = 1'b1; cpu_addr = 15'h0020;
    tick();
    cpu_req = 1'b0;
    repeat (4) tick();
    chk("sim_rb_count", 32'(ack_q.size()), 32'd2);
    if (ack_q.size() > 1) chk("sim_readback", 32'(ack_q[1]), 32'h77);

    // Contention: fetch every 3 cycles with a buffered write
    clr_mon();
    n0 = 0;
    for (int k = 0; k < 8; k++) begin
      cpu_req = 1'b1; cpu_addr = 15'h0100 + 15'(k);
      if (k == 0) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'h40; ioctl_dout = 8'h99; n0 = cyc;
      end
      tick();
      cpu_req = 1'b0; ioctl_wr = 1'b0;
      tick();
      tick();
    end
    repeat (12) tick();
    chk("cont_we_count", 32'(we_q.size()), 32'd1);
    chk("cont_we_cyc", 32'(we_cyc - n0), 32'd7);
    if (we_q.size() > 0) chk("cont_we_entry", 32'(we_q[0]), 32'({15'h0040, 8'h99}));
    chk("cont_ack_count", 32'(ack_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < ack_q.size(); k++)
      chk("cont_ack_data", 32'(ack_q[k]), 32'(8'(k) ^ 8'hC3));
    ioctl_download = 1'b0;
    repeat (6) tick();

    // Reset in the middle of a read
    clr_mon();
    cpu_req = 1'b1; cpu_addr = 15'h0123;
    tick();
    cpu_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk_reset_outs("rdrst");
    reset = 1'b0;
    repeat (4) tick();
    chk("rdrst_no_ack", 32'(ack_q.size()), 32'd0);
    cpu_req = 1'b1; cpu_addr = 15'h0123;
    tick();
    cpu_req = 1'b0;
    chk("rdrst_mem_addr", 32'(mem_addr), 32'h0123);
    tick();
    tick();
    chk("rdrst_ack", 32'(cpu_ack), 32'd1);
    chk("rdrst_data", 32'(cpu_data), 32'h5A);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
